dmem_portb_arbiter: RTL and testbench



---
 rtl/dmem_portb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dmem_portb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_portb_arbiter.sv
// Two-master round-robin arbiter for data memory port B, with locked bursts,
// a bounded lock duration and a configuration mode that blocks requester 1.
module dmem_portb_arbiter #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned LOCK_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conf_sel,
    input  logic              req0,
    input  logic              lock0,
    input  logic [3:0]        we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [31:0]       rdata0,
    input  logic              req1,
    input  logic              lock1,
    input  logic [3:0]        we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [31:0]       rdata1,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_rd,
    input  logic [31:0]       mem_dout
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e          state_q, state_d;
    logic            rr_last_q, rr_last_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            rd_pend0_q, rd_pend0_d;
    logic            rd_pend1_q, rd_pend1_d;

    logic elig1;
    logic cnt_limit;

    assign elig1 = req1 & ~conf_sel;
    // Ownership started with a beat in IDLE, so the counter hitting LOCK_MAX-1
    // on its increment marks the LOCK_MAX-th consecutive owned cycle.
    assign cnt_limit = (int'(lock_cnt_q) + 1) >= (int'(LOCK_MAX) - 1);

    // Grant decision from registered state and the live requests
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0 && elig1) begin
                    if (rr_last_q) gnt0 = 1'b1;
                    else           gnt1 = 1'b1;
                end else begin
                    gnt0 = req0;
                    gnt1 = elig1;
                end
            end
            StOwn0:  gnt0 = req0;
            StOwn1:  gnt1 = elig1;
            default: ;
        endcase
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Memory port B drive: winner's beat, zeros when nobody is granted
    always_comb begin
        mem_we   = 4'b0;
        mem_addr = '0;
        mem_din  = 32'b0;
        mem_rd   = 1'b0;
        if (gnt0) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_din  = wdata0;
            mem_rd   = (we0 == 4'b0);
        end else if (gnt1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_din  = wdata1;
            mem_rd   = (we1 == 4'b0);
        end
    end

    // Read return one cycle after the granted read beat
    always_comb begin
        rd_pend0_d = gnt0 & (we0 == 4'b0);
        rd_pend1_d = gnt1 & (we1 == 4'b0);
        rvalid0    = rd_pend0_q;
        rvalid1    = rd_pend1_q;
        rdata0     = rd_pend0_q ? mem_dout : 32'b0;
        rdata1     = rd_pend1_q ? mem_dout : 32'b0;
    end

    // Lock state machine, round-robin pointer and lock duration counter
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        lock_cnt_d = lock_cnt_q;
        if (gnt0)      rr_last_d = 1'b0;
        else if (gnt1) rr_last_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (gnt0 && lock0) begin
                    state_d    = StOwn0;
                    lock_cnt_d = '0;
                end else if (gnt1 && lock1) begin
                    state_d    = StOwn1;
                    lock_cnt_d = '0;
                end
            end
            StOwn0: begin
                lock_cnt_d = lock_cnt_q + CntW'(1);
                if (cnt_limit) begin
                    // Forced release: the other requester wins the next tie
                    state_d    = StIdle;
                    rr_last_d  = 1'b0;
                    lock_cnt_d = '0;
                end else if ((gnt0 && !lock0) || (!req0 && !lock0)) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end
            end
            StOwn1: begin
                lock_cnt_d = lock_cnt_q + CntW'(1);
                if (cnt_limit) begin
                    state_d    = StIdle;
                    rr_last_d  = 1'b1;
                    lock_cnt_d = '0;
                end else if ((gnt1 && !lock1) || (!req1 && !lock1) || conf_sel) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = StIdle;
                lock_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset drops any in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_last_q  <= 1'b1;
            lock_cnt_q <= '0;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
        end
    end

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Bench for dmem_portb_arbiter: memory model, abstract arbitration model,
// read-data scoreboard queues checked by an independent monitor.
module tb_dmem_portb_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned LM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          conf_sel = 1'b0;
    logic          req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
    logic [3:0]    we0 = 4'h0, we1 = 4'h0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = 32'h0, wdata1 = 32'h0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_rd;
    logic [31:0]   rdata0, rdata1, mem_din;
    logic [31:0]   mem_dout = 32'h0;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;

    logic [31:0] phys   [0:63];
    logic [31:0] shadow [0:63];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Abstract model: current owner (-1 none), cycles owned so far, last winner
    int   owner = -1;
    int   held  = 0;
    bit   last  = 1'b1;
    bit   eg0, eg1;
    logic [1:0] g_dut;

    dmem_portb_arbiter #(.ADDR_W(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst), .conf_sel(conf_sel),
        .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Data memory port B: byte writes, one-cycle synchronous read
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) phys[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        if (mem_rd) mem_dout <= phys[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read-return monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid0) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rvalid0: got unexpected rdata0 %h, expected no response", rdata0);
                end else check("rdata0", 64'(rdata0), 64'(q0.pop_front()));
            end else check("rdata0 idle", 64'(rdata0), 64'h0);
            if (rvalid1) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rvalid1: got unexpected rdata1 %h, expected no response", rdata1);
                end else check("rdata1", 64'(rdata1), 64'(q1.pop_front()));
            end else check("rdata1 idle", 64'(rdata1), 64'h0);
        end
    end

    function automatic void model_grant();
        bit e0, e1;
        e0  = req0;
        e1  = req1 && !conf_sel;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (owner == 0)      eg0 = e0;
        else if (owner == 1) eg1 = e1;
        else if (e0 && e1) begin
            if (last) eg0 = 1'b1;
            else      eg1 = 1'b1;
        end else begin
            eg0 = e0;
            eg1 = e1;
        end
    endfunction

    function automatic void model_update();
        bit rq, lk, g;
        if (eg0)      last = 1'b0;
        else if (eg1) last = 1'b1;
        if (owner < 0) begin
            if (eg0 && lock0)      begin owner = 0; held = 1; end
            else if (eg1 && lock1) begin owner = 1; held = 1; end
        end else begin
            rq = (owner == 0) ? req0 : req1;
            lk = (owner == 0) ? lock0 : lock1;
            g  = (owner == 0) ? eg0 : eg1;
            held++;
            if (held >= LM) begin
                last  = (owner == 1);
                owner = -1;
            end else if ((g && !lk) || (!rq && !lk) || (owner == 1 && conf_sel)) begin
                owner = -1;
            end
        end
    endfunction

    function automatic void shadow_write(input logic [3:0] we, input logic [AW-1:0] a,
                                         input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (we[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    endfunction

    // One bus cycle: predict, compare port B drive at negedge, score reads
    task automatic step();
        logic [44:0] exp_v, act_v;
        model_grant();
        @(negedge clk);
        exp_v = '0;
        if (eg0)      exp_v = {1'b1, 1'b0, we0, we0 == 4'h0, addr0, wdata0};
        else if (eg1) exp_v = {1'b0, 1'b1, we1, we1 == 4'h0, addr1, wdata1};
        act_v = {gnt0, gnt1, mem_we, mem_rd, mem_addr, mem_din};
        check("port", 64'(act_v), 64'(exp_v));
        g_dut = {gnt1, gnt0};
        if (eg0) begin
            if (we0 == 4'h0) q0.push_back(shadow[addr0]);
            else shadow_write(we0, addr0, wdata0);
        end
        if (eg1) begin
            if (we1 == 4'h0) q1.push_back(shadow[addr1]);
            else shadow_write(we1, addr1, wdata1);
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        check("reset ctrl", 64'({gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_rd, mem_addr, mem_din}),
              64'h0);
        check("reset rdata", {rdata0, rdata1}, 64'h0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        owner = -1;
        held  = 0;
        last  = 1'b1;
    endtask

    task automatic idle_both();
        req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    endtask

    task automatic new_beat0();
        req0   = ($urandom_range(0, 99) < 75);
        lock0  = ($urandom_range(0, 99) < 60);
        we0    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        addr0  = AW'($urandom_range(0, 63));
        wdata0 = $urandom;
    endtask

    task automatic new_beat1();
        req1   = ($urandom_range(0, 99) < 75);
        lock1  = ($urandom_range(0, 99) < 60);
        we1    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        addr1  = AW'($urandom_range(0, 63));
        wdata1 = $urandom;
    endtask

    initial begin
        logic [7:0] seq8;
        logic [9:0] seq10;
        int cnt;
        for (int i = 0; i < 64; i++) begin
            phys[i]   = $urandom;
            shadow[i] = phys[i];
        end
        phys[16]   = 32'hDEADBEEF;
        shadow[16] = 32'hDEADBEEF;

        // Single read of 0x10 by requester 0
        do_reset();
        req0 = 1'b1; we0 = 4'h0; addr0 = 6'h10;
        step();
        check("first read gnt", 64'(g_dut), 64'h1);
        idle_both();
        step();

        // Round-robin alternation without locks
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 6'h01; addr1 = 6'h02; we1 = 4'h0;
        seq8 = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            seq8 = {seq8[5:0], g_dut};
        end
        check("rr alternation", 64'(seq8), 64'(8'b01_10_01_10));
        idle_both();
        step();

        // Locked write burst by requester 1, lock dropped on third beat
        do_reset();
        req0 = 1'b1;
        step();
        req1 = 1'b1; lock1 = 1'b1; we1 = 4'b0011; wdata1 = 32'h12345678; addr1 = 6'h03;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) lock1 = 1'b0;
            step();
            if (g_dut == 2'b10) cnt++;
        end
        check("burst gnt1 count", 64'(cnt), 64'd3);
        step();
        check("after burst gnt", 64'(g_dut), 64'h1);
        idle_both();
        step();

        // Lock held past the limit: forced release after LM beats
        do_reset();
        req0 = 1'b1;
        step();
        req1 = 1'b1; lock1 = 1'b1; we1 = 4'h0; addr1 = 6'h05;
        seq10 = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            seq10 = {seq10[7:0], g_dut};
        end
        check("lock timeout", 64'(seq10), 64'(10'b10_10_10_10_01));
        idle_both();
        step();

        // Configuration mode blocks requester 1
        do_reset();
        conf_sel = 1'b1; req1 = 1'b1; we1 = 4'h0; addr1 = 6'h07;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (g_dut != 2'b00) cnt++;
        end
        check("conf_sel blocks", 64'(cnt), 64'd0);
        conf_sel = 1'b0;
        step();
        check("conf_sel release", 64'(g_dut), 64'h2);
        idle_both();
        step();

        // Reset right after a granted read discards it; first tie then goes to 0
        do_reset();
        req0 = 1'b1; we0 = 4'h0; addr0 = 6'h10;
        step();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; lock0 = 1'b0; lock1 = 1'b0; we1 = 4'h0;
        step();
        check("post-reset tie", 64'(g_dut), 64'h1);
        idle_both();
        step();

        // Randomized traffic
        do_reset();
        idle_both();
        for (int i = 0; i < 3000; i++) begin
            if (eg0 || !req0) new_beat0();
            if (eg1 || !req1) new_beat1();
            if ($urandom_range(0, 99) < 3) conf_sel = ~conf_sel;
            step();
        end
        idle_both();
        conf_sel = 1'b0;
        step();
        step();
        check("drain", 64'(q0.size() + q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
